// File: rtl/spiker_adapter_pkg.sv
// Shared types and helpers for the spiker adapter
// (input unpack path and result write-back path).
package spiker_adapter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } writer_state_t;

  function automatic int spiker_n_words(
    input int n_spikes,
    input int width
  );
    return (n_spikes + width - 1) / width;
  endfunction

endpackage

// File: rtl/spiker_word_popcount.sv
// Combinational count of set bits in one word.
// Used by the result writer when SPIKER_RESULT_WRITER_POPCOUNT_EN is set.
module spiker_word_popcount #(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] word,
  output logic [CW-1:0]    ones
);

  always_comb begin
    ones = '0;
    for (int b = 0; b < WIDTH; b++) begin
      ones = ones + CW'(word[b]);
    end
  end

endmodule

// File: rtl/spiker_result_writer.sv
// Packs one spike result vector into words and writes them in order.
// Define SPIKER_RESULT_WRITER_POPCOUNT_EN to enable spike_count_o.
module spiker_result_writer
  import spiker_adapter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int N_SPIKES = 784,
  localparam int N_WORDS = spiker_n_words(N_SPIKES, WIDTH),
  localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1,
  localparam int CNT_W   = $clog2(N_SPIKES + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                spikes_valid_i,
  output logic                spikes_ready_o,
  input  logic [N_SPIKES-1:0] spikes_i,
  output logic                wr_valid_o,
  input  logic                wr_ready_i,
  output logic [IDX_W-1:0]    wr_idx_o,
  output logic [WIDTH-1:0]    wr_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    spike_count_o
);

  writer_state_t state;
  writer_state_t state_nx;

  logic [IDX_W-1:0]                idx;
  logic [N_WORDS-1:0][WIDTH-1:0]   buffer;
  logic [N_WORDS*WIDTH-1:0]        padded;
  logic                            last;

  assign last = (idx == IDX_W'(N_WORDS - 1));

  always_comb begin
    padded = '0;
    padded[N_SPIKES-1:0] = spikes_i;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (spikes_valid_i) state_nx = WRITE;
      WRITE:   if (wr_ready_i && last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      idx    <= '0;
      buffer <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (spikes_valid_i) begin
            buffer <= padded;
            idx    <= '0;
          end
        end
        WRITE: begin
          if (wr_ready_i && !last) idx <= idx + 1'b1;
        end
        DONE:    idx <= '0;
        default: idx <= '0;
      endcase
    end
  end

  // Outputs are decoded purely from registered state and idx.
  assign spikes_ready_o = (state == IDLE);
  assign wr_valid_o     = (state == WRITE);
  assign busy_o         = (state != IDLE);
  assign done_o         = (state == DONE);
  assign wr_idx_o       = idx;
  assign wr_data_o      = (state == WRITE) ? buffer[idx] : '0;

`ifdef SPIKER_RESULT_WRITER_POPCOUNT_EN
  localparam int PC_W = $clog2(WIDTH + 1);

  logic [PC_W-1:0]  ones;
  logic [CNT_W-1:0] count;

  spiker_word_popcount #(
    .WIDTH(WIDTH)
  ) u_popcount (
    .word(wr_data_o),
    .ones(ones)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (state == IDLE && spikes_valid_i) begin
      count <= '0;
    end else if (state == WRITE && wr_ready_i) begin
      count <= count + CNT_W'(ones);
    end
  end

  assign spike_count_o = count;
`else
  assign spike_count_o = '0;
`endif

endmodule

// File: tb/tb_spiker_result_writer.sv
// Directed self-checking bench for spiker_result_writer.
// Expected spike counts follow SPIKER_RESULT_WRITER_POPCOUNT_EN.
module tb_spiker_result_writer;

  localparam int W  = 32;
  localparam int NS = 784;
  localparam int NW = 25;
  localparam int IW = 5;
  localparam int CW = 10;

`ifdef SPIKER_RESULT_WRITER_POPCOUNT_EN
  localparam int EXP_SPARSE = 4;
  localparam int EXP_ONES   = 784;
`else
  localparam int EXP_SPARSE = 0;
  localparam int EXP_ONES   = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          spikes_valid;
  logic          spikes_ready;
  logic [NS-1:0] spikes;
  logic          wr_valid;
  logic          wr_ready;
  logic [IW-1:0] wr_idx;
  logic [W-1:0]  wr_data;
  logic          busy;
  logic          done;
  logic [CW-1:0] spike_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int           acc_idx[$];
  logic [W-1:0] acc_data[$];
  int           cap_cyc[$];
  int           done_cyc[$];

  always #5 clk = ~clk;

  spiker_result_writer #(
    .WIDTH(W),
    .N_SPIKES(NS)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .spikes_valid_i(spikes_valid),
    .spikes_ready_o(spikes_ready),
    .spikes_i(spikes),
    .wr_valid_o(wr_valid),
    .wr_ready_i(wr_ready),
    .wr_idx_o(wr_idx),
    .wr_data_o(wr_data),
    .busy_o(busy),
    .done_o(done),
    .spike_count_o(spike_count)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Records handshakes observed mid-cycle; tests compare these logs.
  always @(negedge clk) begin
    if (!rst) begin
      if (spikes_valid && spikes_ready) cap_cyc.push_back(cyc);
      if (wr_valid && wr_ready) begin
        acc_idx.push_back(int'(wr_idx));
        acc_data.push_back(wr_data);
      end
      if (done) done_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_idx.delete();
    acc_data.delete();
    cap_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic send(input logic [NS-1:0] v);
    spikes = v;
    spikes_valid = 1'b1;
    step();
    spikes_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    total++;
    if (spikes_ready !== 1'b1 || wr_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got rdy=%b val=%b busy=%b done=%b want 1 0 0 0",
               spikes_ready, wr_valid, busy, done);
    end
    total++;
    if (wr_idx !== '0 || wr_data !== '0 || spike_count !== '0) begin
      bad++;
      $display("FAIL reset_data got idx=%0d data=%h cnt=%0d want 0 0 0",
               wr_idx, wr_data, spike_count);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_zero();
    bit ok;
    logic [CW-1:0] cnt;
    clear_logs();
    wr_ready = 1'b1;
    send('0);
    wait_done(ok);
    cnt = spike_count;
    step();
    total++;
    if (!ok) begin bad++; $display("FAIL zero_timeout got no done_o"); end
    total++;
    if (acc_idx.size() != NW) begin
      bad++;
      $display("FAIL zero_count got %0d writes want %0d", acc_idx.size(), NW);
    end
    for (int i = 0; i < acc_idx.size() && i < NW; i++) begin
      total++;
      if (acc_idx[i] != i || acc_data[i] !== 32'h0) begin
        bad++;
        $display("FAIL zero_word got idx=%0d data=%h want idx=%0d data=0",
                 acc_idx[i], acc_data[i], i);
      end
    end
    total++;
    if (done_cyc.size() != 1 || cap_cyc.size() != 1 ||
        done_cyc[0] - cap_cyc[0] != NW + 1) begin
      bad++;
      $display("FAIL zero_done_lat got %0d want %0d",
               done_cyc[0] - cap_cyc[0], NW + 1);
    end
    total++;
    if (cnt !== '0) begin
      bad++;
      $display("FAIL zero_popcount got %0d want 0", cnt);
    end
  endtask

  task automatic test_sparse();
    bit ok;
    logic [CW-1:0] cnt;
    logic [NS-1:0] v;
    logic [W-1:0]  exp_w [NW];
    for (int i = 0; i < NW; i++) exp_w[i] = 32'h0;
    exp_w[0]  = 32'h8000_0001;
    exp_w[1]  = 32'h0000_0001;
    exp_w[24] = 32'h0000_8000;
    v = '0;
    v[0] = 1'b1; v[31] = 1'b1; v[32] = 1'b1; v[783] = 1'b1;
    clear_logs();
    send(v);
    wait_done(ok);
    cnt = spike_count;
    step();
    total++;
    if (!ok || acc_idx.size() != NW) begin
      bad++;
      $display("FAIL sparse_count got ok=%0d writes=%0d want 1 %0d",
               ok, acc_idx.size(), NW);
    end
    for (int i = 0; i < acc_idx.size() && i < NW; i++) begin
      total++;
      if (acc_idx[i] != i || acc_data[i] !== exp_w[i]) begin
        bad++;
        $display("FAIL sparse_word got idx=%0d data=%h want idx=%0d data=%h",
                 acc_idx[i], acc_data[i], i, exp_w[i]);
      end
    end
    total++;
    if (cnt !== CW'(EXP_SPARSE)) begin
      bad++;
      $display("FAIL sparse_popcount got %0d want %0d", cnt, EXP_SPARSE);
    end
    total++;
    if (spike_count !== CW'(EXP_SPARSE)) begin
      bad++;
      $display("FAIL sparse_popcount_hold got %0d want %0d",
               spike_count, EXP_SPARSE);
    end
  endtask

  task automatic test_all_ones();
    bit ok;
    logic [CW-1:0] cnt;
    clear_logs();
    send('1);
    wait_done(ok);
    cnt = spike_count;
    step();
    total++;
    if (!ok || acc_idx.size() != NW) begin
      bad++;
      $display("FAIL ones_count got ok=%0d writes=%0d want 1 %0d",
               ok, acc_idx.size(), NW);
    end
    for (int i = 0; i < acc_idx.size() && i < NW; i++) begin
      total++;
      if (acc_idx[i] != i ||
          acc_data[i] !== ((i == NW - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF)) begin
        bad++;
        $display("FAIL ones_word got idx=%0d data=%h want idx=%0d",
                 acc_idx[i], acc_data[i], i);
      end
    end
    total++;
    if (cnt !== CW'(EXP_ONES)) begin
      bad++;
      $display("FAIL ones_popcount got %0d want %0d", cnt, EXP_ONES);
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [NS-1:0] v;
    v = '0;
    v[5*W +: W] = 32'hA5A5_0F0F;
    clear_logs();
    send(v);
    repeat (5) step();
    wr_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (wr_valid !== 1'b1 || wr_idx !== IW'(5) || wr_data !== 32'hA5A5_0F0F) begin
        bad++;
        $display("FAIL stall_hold got val=%b idx=%0d data=%h want 1 5 a5a50f0f",
                 wr_valid, wr_idx, wr_data);
      end
      step();
    end
    wr_ready = 1'b1;
    wait_done(ok);
    step();
    total++;
    if (!ok || acc_idx.size() != NW) begin
      bad++;
      $display("FAIL stall_count got ok=%0d writes=%0d want 1 %0d",
               ok, acc_idx.size(), NW);
    end
    total++;
    if (acc_idx.size() > 6 &&
        (acc_idx[5] != 5 || acc_data[5] !== 32'hA5A5_0F0F || acc_idx[6] != 6)) begin
      bad++;
      $display("FAIL stall_word got idx=%0d data=%h want 5 a5a50f0f",
               acc_idx[5], acc_data[5]);
    end
    total++;
    if (done_cyc.size() != 1 || cap_cyc.size() != 1 ||
        done_cyc[0] - cap_cyc[0] != NW + 4) begin
      bad++;
      $display("FAIL stall_done_lat got %0d want %0d",
               done_cyc[0] - cap_cyc[0], NW + 4);
    end
  endtask

  task automatic test_back_to_back();
    bit ok1;
    bit ok2;
    logic [NS-1:0] a;
    logic [NS-1:0] b;
    a = '0;
    b = '0;
    a[3*W +: W] = 32'hDEAD_BEEF;
    b[3*W +: W] = 32'h1234_5678;
    clear_logs();
    spikes = a;
    spikes_valid = 1'b1;
    step();
    spikes = b;
    wait_done(ok1);
    step();
    step();
    spikes_valid = 1'b0;
    wait_done(ok2);
    step();
    total++;
    if (!ok1 || !ok2 || cap_cyc.size() != 2 || acc_idx.size() != 2 * NW) begin
      bad++;
      $display("FAIL b2b_count got caps=%0d writes=%0d want 2 %0d",
               cap_cyc.size(), acc_idx.size(), 2 * NW);
    end
    total++;
    if (cap_cyc.size() != 2 || cap_cyc[1] - cap_cyc[0] != NW + 2) begin
      bad++;
      $display("FAIL b2b_period got %0d want %0d",
               cap_cyc[1] - cap_cyc[0], NW + 2);
    end
    total++;
    if (acc_idx.size() == 2 * NW &&
        (acc_data[3] !== 32'hDEAD_BEEF || acc_data[4] !== 32'h0)) begin
      bad++;
      $display("FAIL b2b_first got w3=%h w4=%h want deadbeef 0",
               acc_data[3], acc_data[4]);
    end
    total++;
    if (acc_idx.size() == 2 * NW &&
        (acc_idx[NW] != 0 || acc_idx[NW + 3] != 3 ||
         acc_data[NW + 3] !== 32'h1234_5678)) begin
      bad++;
      $display("FAIL b2b_second got idx=%0d w3=%h want 0 12345678",
               acc_idx[NW], acc_data[NW + 3]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [NS-1:0] v;
    clear_logs();
    send('1);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (wr_valid !== 1'b0 || spikes_ready !== 1'b1 || busy !== 1'b0 ||
        done !== 1'b0 || wr_idx !== '0 || wr_data !== '0) begin
      bad++;
      $display("FAIL rstmid_out got val=%b rdy=%b busy=%b done=%b idx=%0d",
               wr_valid, spikes_ready, busy, done, wr_idx);
    end
    total++;
    if (acc_idx.size() != 10) begin
      bad++;
      $display("FAIL rstmid_partial got %0d writes want 10", acc_idx.size());
    end
    repeat (30) step();
    total++;
    if (done_cyc.size() != 0) begin
      bad++;
      $display("FAIL rstmid_no_done got %0d pulses want 0", done_cyc.size());
    end
    v = '0;
    v[783] = 1'b1;
    clear_logs();
    send(v);
    wait_done(ok);
    step();
    total++;
    if (!ok || acc_idx.size() != NW || acc_idx[0] != 0 ||
        acc_data[NW - 1] !== 32'h0000_8000) begin
      bad++;
      $display("FAIL rstmid_restart got ok=%0d writes=%0d first=%0d last=%h",
               ok, acc_idx.size(), acc_idx[0], acc_data[NW - 1]);
    end
  endtask

  initial begin
    rst = 1'b1;
    spikes_valid = 1'b0;
    spikes = '0;
    wr_ready = 1'b0;
    test_reset();
    test_zero();
    test_sparse();
    test_all_ones();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spiker_result_writer.md
# spiker_result_writer

Write-back end of the spiker adapter. It accepts one N_SPIKES-bit result vector from the spiking core through a valid/ready handshake and packs it into WIDTH-bit words. It then writes the words one at a time, in order, to the register-file result bank over a word-write handshake. The block is the counterpart of the path that unpacks spike input registers into a flat vector for the core.

## Interface
- WIDTH, 32: register word width in bits.
- N_SPIKES, 784: number of 1-bit spikes per result vector.
- Derived: N_WORDS = (N_SPIKES+WIDTH-1)/WIDTH (25 at defaults); IDX_W = max(1,$clog2(N_WORDS)); CNT_W = $clog2(N_SPIKES+1).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- spikes_valid_i  in  1  result vector valid.
- spikes_ready_o  out  1  block can capture a vector.
- spikes_i  in  N_SPIKES  result vector; bit k is spike k.
- wr_valid_o  out  1  word write request.
- wr_ready_i  in  1  register file accepts the word.
- wr_idx_o  out  IDX_W  destination word index.
- wr_data_o  out  WIDTH  word data.
- busy_o  out  1  high in WRITE and DONE.
- done_o  out  1  one-cycle pulse after the last word is accepted.
- spike_count_o  out  CNT_W  number of set spikes in the last vector.

## Operation
- FSM states: IDLE, WRITE, DONE.
- **IDLE**
  - spikes_ready_o=1.
  - When spikes_valid_i&&spikes_ready_o: capture spikes_i into a buffer zero-padded to N_WORDS*WIDTH bits, set idx=0, clear the count, go to WRITE.
- **WRITE**
  - wr_valid_o=1, wr_idx_o=idx, wr_data_o=buffer[idx*WIDTH +: WIDTH].
  - Word i bit b is spike i*WIDTH+b. Pad bits above N_SPIKES-1 are always 0 (last default word: bits 31:16 = 0).
  - When wr_valid_o&&wr_ready_i: if idx==N_WORDS-1, go to DONE; otherwise idx++.
- **DONE**
  - done_o=1 and spikes_ready_o=0 for exactly one cycle, then go to IDLE.
- spikes_ready_o=0 in WRITE and DONE. spikes_i and spikes_valid_i are ignored there.
- Backpressure: while wr_valid_o&&!wr_ready_i, wr_idx_o and wr_data_o hold stable. wr_valid_o never drops before acceptance.
- Words are written strictly in order 0..N_WORDS-1. Each index is written exactly once per vector. idx never wraps past N_WORDS-1.
- Reset values: state=IDLE, idx=0, buffer=0, count=0. Outputs: spikes_ready_o=1, wr_valid_o=0, wr_idx_o=0, wr_data_o=0, busy_o=0, done_o=0, spike_count_o=0.
- Reset during WRITE aborts the transfer. Outputs take reset values the next cycle, no done_o is issued, and partial writes are not retracted.
- Reset has priority over a simultaneous handshake.

## Timing
- All outputs are decoded from registered state and idx; there is no combinational input-to-output path except none at all.
- Capture at cycle T. First wr_valid_o at T+1.
- With wr_ready_i held high: word i is accepted at T+1+i, the last word at T+N_WORDS, done_o at T+N_WORDS+1, spikes_ready_o=1 again at T+N_WORDS+2.
- Each stall cycle on wr_ready_i delays all later events by one cycle.
- Minimum vector period is N_WORDS+2 cycles (27 at defaults).

## Configuration
- SPIKER_RESULT_WRITER_POPCOUNT_EN defined:
  - On each accepted word, count += popcount(wr_data_o).
  - spike_count_o = count. It is final when done_o is high and held until the next capture clears it.
- Not defined:
  - No counter logic; spike_count_o is tied to 0.
  - The port is still present, so the interface is unchanged.

## Structure
- Shared package spiker_adapter_pkg holds:
  - the typedef enum for the writer states {IDLE, WRITE, DONE};
  - a function spiker_n_words(n_spikes, width) returning the ceiling division, used here and by the input unpack path.
- Sub-module spiker_word_popcount (parameter WIDTH; combinational WIDTH-bit in, $clog2(WIDTH+1)-bit count out). It is instantiated only under the macro.

## Test plan
- Reset, then all spikes 0 with wr_ready_i=1 → 25 writes, idx 0..24, all data 0x00000000. done_o at T+26; spike_count_o=0.
- Only spikes 0, 31, 32 and 783 set → word0=0x80000001, word1=0x00000001, word24=0x00008000, all others 0. spike_count_o=4 with the macro, 0 without.
- All spikes 1 → words 0..23 = 0xFFFFFFFF, word24=0x0000FFFF. spike_count_o=784 with the macro.
- wr_ready_i low for 3 cycles on word 5 → wr_idx_o=5 and its data held stable. done_o is delayed to T+29.
- spikes_valid_i held high across two vectors → the second vector is captured only at T+27. Pulsing valid during WRITE changes nothing.
- rst_i asserted at the write of word 10 → next cycle wr_valid_o=0 and spikes_ready_o=1, no done_o. A new vector afterwards writes from idx 0.
